// File: rtl/writeback_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_unit_if
//  Description : Request / writeback bundle between the pipeline, data memory
//                and the writeback_unit. The csr_rdata member exists only when
//                WB_CSR_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface writeback_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      sel_wb;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd_addr;
    logic            reg_we;
    logic [2:0]      funct3;
    logic [2:0]      addr_lsb;
    logic [XLEN-1:0] dmem_rdata;
    logic            dmem_rvalid;
`ifdef WB_CSR_EN
    logic [XLEN-1:0] csr_rdata;
`endif
    logic            wb_valid;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            stall;
    logic            load_err;

    modport master (
        output in_valid, sel_wb, alu_out, pc, rd_addr, reg_we, funct3, addr_lsb,
        output dmem_rdata, dmem_rvalid,
`ifdef WB_CSR_EN
        output csr_rdata,
`endif
        input  in_ready, wb_valid, wb_we, wb_rd, wb_data, stall, load_err
    );

    modport slave (
        input  in_valid, sel_wb, alu_out, pc, rd_addr, reg_we, funct3, addr_lsb,
        input  dmem_rdata, dmem_rvalid,
`ifdef WB_CSR_EN
        input  csr_rdata,
`endif
        output in_ready, wb_valid, wb_we, wb_rd, wb_data, stall, load_err
    );
endinterface
`default_nettype wire

// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_unit
//  Description : Selects ALU / load / pc+4 / CSR result, aligns load data and
//                waits (with timeout) for late memory data. Optional CSR source
//                enabled by defining WB_CSR_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module writeback_unit #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 15
) (
    input  wire logic           clk,
    input  wire logic           rst,
    writeback_unit_if.slave     bus
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    state_t          state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [4:0]      rd_q,       rd_d;
    logic            reg_we_q,   reg_we_d;
    logic [2:0]      funct3_q,   funct3_d;
    logic [2:0]      lsb_q,      lsb_d;
    logic            wb_valid_q, wb_valid_d;
    logic            wb_we_q,    wb_we_d;
    logic [4:0]      wb_rd_q,    wb_rd_d;
    logic [XLEN-1:0] wb_data_q,  wb_data_d;
    logic            load_err_q, load_err_d;

    // Shifting the word right by the lane offset puts the addressed byte,
    // halfword or word at bit 0; the case then sign- or zero-extends it.
    function automatic logic [XLEN-1:0] align_load(
        input logic [2:0]      f3,
        input logic [2:0]      lsb,
        input logic [XLEN-1:0] rdata
    );
        logic [2:0]      boff;
        logic [1:0]      hoff;
        logic            woff;
        logic [XLEN-1:0] bsh;
        logic [XLEN-1:0] hsh;
        logic [XLEN-1:0] wsh;
        logic [XLEN-1:0] res;
        boff = (XLEN == 64) ? lsb      : {1'b0, lsb[1:0]};
        hoff = (XLEN == 64) ? lsb[2:1] : {1'b0, lsb[1]};
        woff = (XLEN == 64) ? lsb[2]   : 1'b0;
        bsh  = rdata >> {boff, 3'b000};
        hsh  = rdata >> {hoff, 4'b0000};
        wsh  = rdata >> {woff, 5'b00000};
        res  = rdata;
        case (f3)
            3'b000: begin res = {XLEN{bsh[7]}};  res[7:0]  = bsh[7:0];  end
            3'b001: begin res = {XLEN{hsh[15]}}; res[15:0] = hsh[15:0]; end
            3'b010: begin res = {XLEN{wsh[31]}}; res[31:0] = wsh[31:0]; end
            3'b100: begin res = '0;              res[7:0]  = bsh[7:0];  end
            3'b101: begin res = '0;              res[15:0] = hsh[15:0]; end
            3'b110: begin res = '0;              res[31:0] = wsh[31:0]; end
            default: res = rdata;
        endcase
        return res;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        reg_we_d   = reg_we_q;
        funct3_d   = funct3_q;
        lsb_d      = lsb_q;
        wb_valid_d = 1'b0;
        wb_we_d    = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        load_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    wb_valid_d = 1'b1;
                    wb_we_d    = bus.reg_we && (bus.rd_addr != 5'd0);
                    wb_rd_d    = bus.rd_addr;
                    case (bus.sel_wb)
                        2'b00: wb_data_d = bus.alu_out;
                        2'b10: wb_data_d = bus.pc + XLEN'(4);
                        2'b01: begin
                            if (bus.dmem_rvalid) begin
                                wb_data_d = align_load(bus.funct3, bus.addr_lsb, bus.dmem_rdata);
                            end else begin
                                wb_valid_d = 1'b0;
                                wb_we_d    = 1'b0;
                                state_d    = WAIT_MEM;
                                cnt_d      = '0;
                                rd_d       = bus.rd_addr;
                                reg_we_d   = bus.reg_we;
                                funct3_d   = bus.funct3;
                                lsb_d      = bus.addr_lsb;
                            end
                        end
                        default: begin
`ifdef WB_CSR_EN
                            wb_data_d = bus.csr_rdata;
`else
                            wb_data_d = bus.alu_out;
`endif
                        end
                    endcase
                end
            end
            WAIT_MEM: begin
                // Data arriving on the timeout cycle still takes priority.
                if (bus.dmem_rvalid) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_we_d    = reg_we_q && (rd_q != 5'd0);
                    wb_rd_d    = rd_q;
                    wb_data_d  = align_load(funct3_q, lsb_q, bus.dmem_rdata);
                end else if (cnt_q >= C_CNT_LAST) begin
                    state_d    = IDLE;
                    cnt_d      = cnt_q + CNT_W'(1);
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = '0;
                    load_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_q       <= '0;
            reg_we_q   <= 1'b0;
            funct3_q   <= '0;
            lsb_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            reg_we_q   <= reg_we_d;
            funct3_q   <= funct3_d;
            lsb_q      <= lsb_d;
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.in_ready = (state_q == IDLE);
    assign bus.stall    = (state_q == WAIT_MEM);
    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_we    = wb_we_q;
    assign bus.wb_rd    = wb_rd_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.load_err = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_writeback_unit
//  Description : Directed self-checking bench for writeback_unit (XLEN=32,
//                TIMEOUT=4); CSR expectation follows WB_CSR_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_unit;

    localparam int XLEN    = 32;
    localparam int TIMEOUT = 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    writeback_unit_if #(.XLEN(XLEN)) bus ();

    writeback_unit #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] pcv,
                       input logic [4:0] rd, input logic we, input logic [2:0] f3,
                       input logic [2:0] lsb, input logic [31:0] rdata, input logic rvalid);
        bus.in_valid    = 1'b1;
        bus.sel_wb      = sel;
        bus.alu_out     = alu;
        bus.pc          = pcv;
        bus.rd_addr     = rd;
        bus.reg_we      = we;
        bus.funct3      = f3;
        bus.addr_lsb    = lsb;
        bus.dmem_rdata  = rdata;
        bus.dmem_rvalid = rvalid;
    endtask

    task automatic pulse(input string tag, input logic we, input logic [4:0] rd,
                         input logic [31:0] data, input logic err);
        chk({tag, ".valid"}, {63'd0, bus.wb_valid}, 64'd1);
        chk({tag, ".we"},    {63'd0, bus.wb_we},    {63'd0, we});
        chk({tag, ".rd"},    {59'd0, bus.wb_rd},    {59'd0, rd});
        chk({tag, ".data"},  {32'd0, bus.wb_data},  {32'd0, data});
        chk({tag, ".err"},   {63'd0, bus.load_err}, {63'd0, err});
    endtask

    task automatic load(input string tag, input logic [2:0] f3, input logic [2:0] lsb,
                        input logic [31:0] exp);
        req(2'b01, 32'h0, 32'h0, 5'd6, 1'b1, f3, lsb, 32'h80FF_7F01, 1'b1);
        cyc();
        bus.in_valid    = 1'b0;
        bus.dmem_rvalid = 1'b0;
        pulse(tag, 1'b1, 5'd6, exp, 1'b0);
        chk({tag, ".ready"}, {63'd0, bus.in_ready}, 64'd1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        req(2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 3'd0, 3'd0, 32'h0, 1'b0);
        bus.in_valid = 1'b0;
`ifdef WB_CSR_EN
        bus.csr_rdata = 32'h0;
`endif
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst.valid", {63'd0, bus.wb_valid}, 64'd0);
        chk("rst.we",    {63'd0, bus.wb_we},    64'd0);
        chk("rst.data",  {32'd0, bus.wb_data},  64'd0);
        chk("rst.err",   {63'd0, bus.load_err}, 64'd0);
        chk("rst.ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rst.stall", {63'd0, bus.stall},    64'd0);

        // ALU path and single-cycle strobe
        req(2'b00, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 3'd0, 3'd0, 32'h0, 1'b0);
        cyc();
        bus.in_valid = 1'b0;
        pulse("alu", 1'b1, 5'd5, 32'h0000_1234, 1'b0);
        cyc();
        chk("alu.drop.valid", {63'd0, bus.wb_valid}, 64'd0);
        chk("alu.drop.we",    {63'd0, bus.wb_we},    64'd0);

        // pc+4 wrap
        req(2'b10, 32'h0, 32'hFFFF_FFFC, 5'd1, 1'b1, 3'd0, 3'd0, 32'h0, 1'b0);
        cyc();
        bus.in_valid = 1'b0;
        pulse("pc4", 1'b1, 5'd1, 32'h0000_0000, 1'b0);

        // Immediate loads from 0x80FF_7F01
        load("lb3",  3'b000, 3'd3, 32'hFFFF_FF80);
        load("lbu3", 3'b100, 3'd3, 32'h0000_0080);
        load("lh2",  3'b001, 3'd2, 32'hFFFF_80FF);
        load("lh3",  3'b001, 3'd3, 32'hFFFF_80FF);
        load("lhu0", 3'b101, 3'd0, 32'h0000_7F01);
        load("lw",   3'b010, 3'd0, 32'h80FF_7F01);
        load("ld32", 3'b011, 3'd0, 32'h80FF_7F01);
        load("lb1",  3'b000, 3'd1, 32'h0000_007F);

        // Wait path: rvalid three cycles after accept, rd=0, in_valid ignored while waiting
        req(2'b01, 32'h0, 32'h0, 5'd0, 1'b1, 3'b000, 3'd0, 32'h0, 1'b0);
        cyc();
        bus.in_valid = 1'b0;
        bus.rd_addr  = 5'd7;
        bus.funct3   = 3'b111;
        chk("wait1.stall", {63'd0, bus.stall},    64'd1);
        chk("wait1.ready", {63'd0, bus.in_ready}, 64'd0);
        chk("wait1.valid", {63'd0, bus.wb_valid}, 64'd0);
        bus.in_valid = 1'b1;
        bus.sel_wb   = 2'b00;
        cyc();
        chk("wait2.stall", {63'd0, bus.stall},    64'd1);
        chk("wait2.valid", {63'd0, bus.wb_valid}, 64'd0);
        bus.in_valid = 1'b0;
        cyc();
        chk("wait3.stall", {63'd0, bus.stall},    64'd1);
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h0000_00FF;
        cyc();
        bus.dmem_rvalid = 1'b0;
        pulse("waitdone", 1'b0, 5'd0, 32'hFFFF_FFFF, 1'b0);
        chk("waitdone.stall", {63'd0, bus.stall}, 64'd0);
        cyc();
        chk("waitdone.drop", {63'd0, bus.wb_valid}, 64'd0);

        // Timeout: four wait cycles with no data
        req(2'b01, 32'h0, 32'h0, 5'd9, 1'b1, 3'b010, 3'd0, 32'h0, 1'b0);
        for (int i = 1; i <= TIMEOUT; i++) begin
            cyc();
            bus.in_valid = 1'b0;
            chk("to.stall", {63'd0, bus.stall},    64'd1);
            chk("to.quiet", {63'd0, bus.wb_valid}, 64'd0);
        end
        req(2'b00, 32'h0000_0055, 32'h0, 5'd1, 1'b1, 3'd0, 3'd0, 32'h0, 1'b0);
        bus.in_valid = 1'b0;
        cyc();
        pulse("timeout", 1'b0, 5'd9, 32'h0, 1'b1);
        chk("timeout.ready", {63'd0, bus.in_ready}, 64'd1);
        bus.in_valid = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        pulse("after_to", 1'b1, 5'd1, 32'h0000_0055, 1'b0);

        // rvalid on the timeout cycle: data wins
        req(2'b01, 32'h0, 32'h0, 5'd4, 1'b1, 3'b100, 3'd1, 32'h0, 1'b0);
        cyc();
        bus.in_valid = 1'b0;
        cyc();
        cyc();
        cyc();
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h0000_AB00;
        cyc();
        bus.dmem_rvalid = 1'b0;
        pulse("race", 1'b1, 5'd4, 32'h0000_00AB, 1'b0);

        // Reset in the middle of a wait abandons the load
        req(2'b01, 32'h0, 32'h0, 5'd8, 1'b1, 3'b010, 3'd0, 32'h0, 1'b0);
        cyc();
        bus.in_valid = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rstwait.ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rstwait.stall", {63'd0, bus.stall},    64'd0);
        for (int i = 0; i < 6; i++) begin
            chk("rstwait.nopulse", {62'd0, bus.wb_valid, bus.load_err}, 64'd0);
            cyc();
        end

        // CSR / reserved source
        req(2'b11, 32'h0000_1111, 32'h0, 5'd3, 1'b1, 3'd0, 3'd0, 32'h0, 1'b0);
`ifdef WB_CSR_EN
        bus.csr_rdata = 32'h0000_ABCD;
`endif
        cyc();
        bus.in_valid = 1'b0;
`ifdef WB_CSR_EN
        pulse("csr", 1'b1, 5'd3, 32'h0000_ABCD, 1'b0);
`else
        pulse("csr", 1'b1, 5'd3, 32'h0000_1111, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the datapath width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter TIMEOUT, default 15, meaning the maximum number of wait cycles for load data before an error.
REQ-003 The block SHALL have one clock and a synchronous active-high reset: clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  writeback request present.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 sel_wb  input  2  source select: 00 ALU, 01 memory, 10 pc+4, 11 CSR/reserved.
REQ-008 alu_out  input  XLEN  ALU result.
REQ-009 pc  input  XLEN  instruction address.
REQ-010 rd_addr  input  5  destination register.
REQ-011 reg_we  input  1  instruction writes the register file.
REQ-012 funct3  input  3  load size/sign code.
REQ-013 addr_lsb  input  3  low load-address bits; bit 2 is ignored when XLEN=32.
REQ-014 dmem_rdata  input  XLEN  raw memory word.
REQ-015 dmem_rvalid  input  1  memory data valid.
REQ-016 csr_rdata  input  XLEN  CSR read data; this port is present only under WB_CSR_EN.
REQ-017 wb_valid  output  1  registered one-cycle writeback strobe.
REQ-018 wb_we  output  1  register-file write enable.
REQ-019 wb_rd  output  5  destination register.
REQ-020 wb_data  output  XLEN  write data.
REQ-021 stall  output  1  pipeline hold request.
REQ-022 load_err  output  1  one-cycle load-timeout pulse.

Function
REQ-023 The FSM SHALL have two states, IDLE and WAIT_MEM; in_ready = (state==IDLE), and stall = (state==WAIT_MEM).
REQ-024 A request SHALL be accepted when in_valid && in_ready.
- Its result appears on wb_* exactly one cycle later, with wb_valid high for that single cycle.
REQ-025 For sel_wb=00, wb_data SHALL equal alu_out.
REQ-026 For sel_wb=10, wb_data SHALL equal pc+4 truncated to XLEN bits, so all-ones minus 3 wraps to 0.
REQ-027 For sel_wb=01 with dmem_rvalid high in the accept cycle, the aligned load data SHALL be written back at latency 1 and the FSM SHALL stay in IDLE.
REQ-028 For sel_wb=01 with dmem_rvalid low, the FSM SHALL enter WAIT_MEM.
- It latches rd_addr, reg_we, funct3 and addr_lsb.
- It clears the wait counter.
REQ-029 In WAIT_MEM, the first cycle with dmem_rvalid high SHALL register the aligned data and return to IDLE; wb_valid is high the following cycle.
REQ-030 In WAIT_MEM, the wait counter SHALL increment once per cycle without rvalid.
- When it reaches TIMEOUT, the block returns to IDLE and, next cycle, pulses wb_valid=1, wb_we=0, load_err=1 and wb_data=0.
REQ-031 If dmem_rvalid and the timeout occur in the same cycle, the data SHALL win and load_err SHALL stay 0.
REQ-032 Load alignment SHALL be applied as follows:
- 000 LB: byte at addr_lsb, sign-extended.
- 001 LH: halfword at addr_lsb[2:1], sign-extended; addr_lsb[0] is ignored.
- 010 LW: word at addr_lsb[2] (XLEN=64) or the full word (XLEN=32), sign-extended.
- 011 LD: full word (XLEN=64 only).
- 100 LBU, 101 LHU, 110 LWU: zero-extended.
- 111, or 011 when XLEN=32: raw dmem_rdata.
REQ-033 wb_we SHALL equal the latched reg_we && (rd != 0) on every wb_valid pulse except a timeout pulse.
REQ-034 wb_we SHALL be 0 whenever wb_valid is 0.
REQ-035 in_valid while in WAIT_MEM SHALL be ignored; the upstream stage holds its request under stall.
REQ-036 A request that is not accepted SHALL produce no wb_valid pulse.

Reset
REQ-037 On rst, the state SHALL become IDLE, the wait counter 0, and wb_valid, wb_we, wb_rd, wb_data and load_err 0.
REQ-038 A reset asserted during WAIT_MEM SHALL abandon the load with no wb_valid or load_err pulse.
- in_ready is 1 in the first cycle after rst deasserts.

Configuration
REQ-039 Macro WB_CSR_EN SHALL control the CSR source.
- When defined, the csr_rdata port exists and sel_wb=11 selects csr_rdata at latency 1.
- When undefined, the port is absent and sel_wb=11 behaves exactly as sel_wb=00.

Verification
REQ-040 ALU path: accept sel=00, alu_out=0x0000_1234, rd=5 -> next cycle wb_valid=1, wb_we=1, wb_rd=5, wb_data=0x0000_1234; on the cycle after that, wb_valid=0.
REQ-041 pc+4 wrap: sel=10, pc=0xFFFF_FFFC -> wb_data=0x0000_0000.
REQ-042 Load alignment: rdata=0x80FF_7F01.
- LB lsb=3 -> 0xFFFF_FF80.
- LBU lsb=3 -> 0x0000_0080.
- LH lsb=2 -> 0xFFFF_80FF.
- LHU lsb=0 -> 0x0000_7F01.
REQ-043 Wait path: sel=01, rvalid arrives 3 cycles after accept -> stall high for 3 cycles, in_ready low, a single wb_valid pulse carrying the latched rd; rd=0 -> wb_we=0.
REQ-044 Timeout: TIMEOUT=4, rvalid never arrives -> after 4 wait cycles, a pulse with load_err=1, wb_we=0, wb_data=0; the next request is accepted. With rvalid and timeout in the same cycle -> data written back, load_err=0.
REQ-045 Reset mid-wait, and CSR: rst during WAIT_MEM -> no pulse and in_ready=1 afterwards; sel=11 with csr_rdata=0xABCD -> wb_data=0xABCD under WB_CSR_EN, and alu_out without it.
